// File: rtl/mem_seq_ctrl_pkg.sv
// Shared definitions for the data-memory sequencer: state encoding,
// default timeout and datapath width, and the timeout counter width.
package mem_seq_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_ISSUE  = 3'd1;
    localparam state_t S_WAIT   = 3'd2;
    localparam state_t S_DONE   = 3'd3;
    localparam state_t S_HALTED = 3'd4;

    localparam int TIMEOUT_DEF = 64;
    localparam int AW_DEF      = 16;

    // Wide enough for the largest legal TIMEOUT (255).
    localparam int CW = 8;

endpackage

// File: rtl/mem_seq_timer.sv
// Loadable up-counter with clear, used to time out memory accesses.
// Ports: clk, rst_n, clr, ld/ld_val, inc in; tc (count == LIMIT-1) out.
module mem_seq_timer
    import mem_seq_ctrl_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    input  logic          inc,
    output logic          tc
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_seq_ctrl.sv
// Multi-cycle data-memory sequencer: turns a one-cycle MemRead/MemWrite
// into a memory handshake, stalls the core meanwhile, gates RegWrite and
// holds a sticky halt. Inputs: decoder controls, addr, wdata, mem_rdata,
// mem_done. Outputs: mem_en/wr/addr/wdata, stall, rdata, RegWrite_out,
// err, halted. Optional MEM_ALIGN_CHK_EN rejects odd addresses.
module mem_seq_ctrl
    import mem_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int AW      = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic          RegWrite,
    input  logic          Halt,
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] wdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    input  logic [AW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          stall,
    output logic [AW-1:0] rdata,
    output logic          RegWrite_out,
    output logic          err,
    output logic          halted
);

    state_t        state;
    state_t        nxt;
    logic          wr_q;
    logic          rw_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] wdata_q;
    logic [AW-1:0] rdata_q;
    logic          req;
    logic          ill;
    logic          mis;
    logic          tc;
    logic          tmo;

    assign req = MemRead | MemWrite;
    assign ill = MemRead & MemWrite;

`ifdef MEM_ALIGN_CHK_EN
    assign mis = req & addr[0];
`else
    assign mis = 1'b0;
`endif

    // mem_done wins over a simultaneous terminal count.
    assign tmo = (state == S_WAIT) & tc & ~mem_done;

    mem_seq_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == S_ISSUE),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (state == S_WAIT),
        .tc     (tc)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    nxt = mis ? S_DONE : S_ISSUE;
                end else if (Halt) begin
                    nxt = S_HALTED;
                end
            end
            S_ISSUE:  nxt = S_WAIT;
            S_WAIT: begin
                if (mem_done || tc) begin
                    nxt = S_DONE;
                end
            end
            S_DONE:   nxt = S_IDLE;
            S_HALTED: nxt = S_HALTED;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wr_q    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && req) begin
                // Illegal read+write is treated as a write.
                wr_q    <= MemWrite;
                rw_q    <= RegWrite & ~mis;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == S_WAIT) begin
                if (mem_done) begin
                    if (!wr_q) begin
                        rdata_q <= mem_rdata;
                    end
                end else if (tc) begin
                    rdata_q <= '0;
                end
            end
        end
    end

    always_comb begin
        stall        = 1'b0;
        RegWrite_out = 1'b0;
        err          = 1'b0;
        unique case (1'b1)
            (state == S_IDLE): begin
                stall        = req;
                RegWrite_out = req ? 1'b0 : RegWrite;
                err          = req & (ill | mis);
            end
            (state == S_ISSUE): stall = 1'b1;
            (state == S_WAIT): begin
                stall = 1'b1;
                err   = tmo;
            end
            (state == S_DONE): RegWrite_out = rw_q;
            (state == S_HALTED): stall = 1'b1;
            default: ;
        endcase
    end

    assign mem_en    = (state == S_ISSUE);
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign halted    = (state == S_HALTED);

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Scoreboard bench for mem_seq_ctrl with TIMEOUT=4.
// Driver queues expectations; monitor and memory responder consume them.
module tb_mem_seq_ctrl;

    localparam int AW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          MemRead = 1'b0;
    logic          MemWrite = 1'b0;
    logic          RegWrite = 1'b0;
    logic          Halt = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [AW-1:0] wdata = '0;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] mem_wdata;
    logic [AW-1:0] mem_rdata = '0;
    logic          mem_done = 1'b0;
    logic          stall;
    logic [AW-1:0] rdata;
    logic          RegWrite_out;
    logic          err;
    logic          halted;

    mem_seq_ctrl #(
        .TIMEOUT (TO),
        .AW      (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .Halt         (Halt),
        .addr         (addr),
        .wdata        (wdata),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .stall        (stall),
        .rdata        (rdata),
        .RegWrite_out (RegWrite_out),
        .err          (err),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [AW-1:0] d;
    } req_t;

    typedef struct {
        int            k;
        logic [AW-1:0] d;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic          rw;
        int            errs;
        int            run;
    } done_t;

    req_t  req_q[$];
    rsp_t  rsp_q[$];
    done_t done_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int en_cnt = 0;
    logic [AW-1:0] exp_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: checks memory requests and access completions.
    int run = 0;
    int errs = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
            errs = 0;
        end else begin
            if (mem_en) begin
                en_cnt++;
                if (req_q.size() == 0) begin
                    chk("mem_en_spurious", mem_en, 0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("mem_wr", mem_wr, r.wr);
                    chk("mem_addr", mem_addr, r.a);
                    if (r.wr) chk("mem_wdata", mem_wdata, r.d);
                end
            end
            if (err) errs++;
            if (stall && !halted) begin
                run++;
            end else if (!stall && run > 0) begin
                chk("completion_q", done_q.size() > 0, 1);
                if (done_q.size() > 0) begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("done_rdata", rdata, e.rd);
                    chk("done_regwrite", RegWrite_out, e.rw);
                    chk("done_errs", errs, e.errs);
                    chk("stall_cycles", run, e.run);
                end
                run = 0;
                errs = 0;
            end
        end
    end

    // Memory responder: raise mem_done in WAIT cycle k after mem_en.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_en && rsp_q.size() > 0) begin
                rsp_t r;
                r = rsp_q.pop_front();
                repeat (r.k) @(posedge clk);
                #1;
                mem_done = 1'b1;
                mem_rdata = r.d;
                @(posedge clk);
                #1;
                mem_done = 1'b0;
                mem_rdata = AW'($urandom);
            end
        end
    end

    task automatic garbage();
        MemRead = 1'($urandom);
        MemWrite = 1'($urandom);
        RegWrite = 1'($urandom);
        Halt = 1'($urandom);
        addr = AW'($urandom);
        wdata = AW'($urandom);
    endtask

    task automatic quiet();
        MemRead = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        Halt = 1'b0;
    endtask

    task automatic pass(input logic rw);
        @(posedge clk);
        #1;
        quiet();
        RegWrite = rw;
        addr = AW'($urandom);
        @(negedge clk);
        chk("pass_stall", stall, 0);
        chk("pass_regwrite", RegWrite_out, rw);
        chk("pass_err", err, 0);
    endtask

    // k = WAIT cycle (1-based) in which the memory answers.
    task automatic issue(input logic rd, input logic wr, input logic rw,
                         input logic [AW-1:0] a, input logic [AW-1:0] d,
                         input int k, input logic [AW-1:0] dat);
        logic  mis;
        done_t e;
        int    n;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
        mis = a[0];
`endif
        if (mis) begin
            e.errs = 1;
            e.run = 1;
            e.rw = 1'b0;
        end else begin
            req_q.push_back('{wr, a, d});
            rsp_q.push_back('{k, dat});
            if (k <= TO) begin
                if (!wr) exp_rd = dat;
                e.errs = (rd && wr) ? 1 : 0;
                e.run = 2 + k;
            end else begin
                exp_rd = '0;
                e.errs = (rd && wr) ? 2 : 1;
                e.run = 2 + TO;
            end
            e.rw = rw;
        end
        e.rd = exp_rd;
        done_q.push_back(e);
        @(posedge clk);
        #1;
        MemRead = rd;
        MemWrite = wr;
        RegWrite = rw;
        Halt = 1'b0;
        addr = a;
        wdata = d;
        @(negedge clk);
        chk("req_stall", stall, 1);
        chk("req_regwrite", RegWrite_out, 0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            garbage();
            @(negedge clk);
            n++;
        end while (stall && n < 20);
        chk("access_end", stall, 0);
    endtask

    task automatic chk_reset();
        chk("rst_ctrl", {mem_en, mem_wr, stall, RegWrite_out, err, halted}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0;
        quiet();
        repeat (2) @(negedge clk);
        chk_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed: load, store, timeout.
        issue(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 2, 16'hBEEF);
        issue(1'b0, 1'b1, 1'b0, 16'h0102, 16'h1234, 1, 16'h5555);
        issue(1'b1, 1'b0, 1'b1, 16'h0044, 16'h0000, 6, 16'h7777);
`ifdef MEM_ALIGN_CHK_EN
        issue(1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, 1, 16'h9999);
`endif

        for (int i = 0; i < 200; i++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind < 3) begin
                pass(1'($urandom));
            end else begin
                issue(kind == 9 || kind < 6, kind >= 6,
                      1'($urandom), AW'($urandom), AW'($urandom),
                      int'($urandom_range(1, 6)), AW'($urandom));
            end
        end

        // Sticky halt.
        @(posedge clk);
        #1;
        quiet();
        Halt = 1'b1;
        @(posedge clk);
        #1;
        quiet();
        en0 = en_cnt;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("halt_state", {halted, stall, RegWrite_out, mem_en}, 4'b1100);
            @(posedge clk);
            #1;
            garbage();
        end
        chk("halt_no_mem_en", en_cnt - en0, 0);
        quiet();
        rst_n = 1'b0;
        exp_rd = '0;
        @(negedge clk);
        chk_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset during WAIT drops the access.
        req_q.push_back('{1'b1, 16'h0200, 16'hCAFE});
        rsp_q.push_back('{6, 16'h0000});
        @(posedge clk);
        #1;
        MemWrite = 1'b1;
        addr = 16'h0200;
        wdata = 16'hCAFE;
        @(posedge clk);
        #1;
        quiet();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_rd = '0;
        @(negedge clk);
        chk("midrst_stall", stall, 0);
        chk("midrst_regwrite", RegWrite_out, 0);
        chk_reset();
        en0 = en_cnt;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_no_mem_en", en_cnt - en0, 0);
        chk("midrst_idle_stall", stall, 0);

        for (int i = 0; i < 20; i++) begin
            issue(1'b1, 1'b0, 1'b1, AW'($urandom), 16'h0000,
                  int'($urandom_range(1, 6)), AW'($urandom));
        end

        repeat (10) @(negedge clk);
        chk("req_q_empty", req_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
